nas_vid_rx: RTL and testbench
=============================

NAS_VID_RX -- requirements
Module: nas_vid_rx

Interface
REQ-001 SHALL have parameter H_START, default 200: clk cycles from hsync trailing (rising) edge to first dot sample.
REQ-002 SHALL have parameter V_START, default 16: hsyncs after vsync trailing edge before first captured line.
REQ-003 SHALL have parameter DOTS, default 384: dots per captured line, a multiple of 8.
REQ-004 SHALL have parameter LINES, default 256: captured lines per frame.
REQ-005 SHALL have parameters HSYNC_MIN 32, HSYNC_MAX 96, VSYNC_MIN 1024: sync-low widths in clk cycles.
REQ-006 SHALL have port clk, input, 1: 16MHz sample clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port vid_sync, input, 1: async composite sync, low = sync.
REQ-009 SHALL have port vid_data, input, 1: async dot data, 1 = lit.
REQ-010 SHALL have ports px_we (output, 1), px_addr (output, 14) and px_data (output, 8): capture-buffer byte write.
REQ-011 SHALL have ports frame_done (output, 1), a one-cycle pulse, and locked (output, 1), high after the first valid vsync.
REQ-012 SHALL have port err_cnt, output, 8: saturating sync error count.

Function
REQ-013 SHALL pass vid_sync and vid_data through 2-flop synchronisers; all logic SHALL use the synchronised signals.
REQ-014 SHALL count clk cycles while sync is low, saturating at VSYNC_MIN, and classify the pulse on the rising edge.
REQ-015 SHALL classify width >= VSYNC_MIN as vsync, HSYNC_MIN..HSYNC_MAX as hsync, and anything else as a glitch that is otherwise ignored.
REQ-016 SHALL use states IDLE, VPORCH, HWAIT, HPORCH, CAPT.
REQ-017 SHALL move IDLE->VPORCH on vsync.
REQ-018 SHALL move VPORCH->HWAIT after V_START hsyncs.
REQ-019 SHALL move HWAIT->HPORCH on hsync.
REQ-020 SHALL move HPORCH->CAPT after H_START cycles.
REQ-021 SHALL move CAPT->HWAIT after DOTS samples, or CAPT->IDLE after the LINES-th line completes.
REQ-022 SHALL sample one dot every 2 clk cycles in CAPT, starting on the first CAPT cycle.
REQ-023 SHALL put the first dot of each byte in px_data[7].
REQ-024 SHALL pulse px_we for one cycle, the cycle after the 8th dot of each byte is sampled.
REQ-025 SHALL set px_addr = line*(DOTS/8) + byte index, starting at 0 each frame.
REQ-026 SHALL pulse frame_done in the same cycle as the final px_we of line LINES-1.
REQ-027 SHALL set locked on the first vsync and clear it only on reset.
REQ-028 SHALL, on vsync in any state other than IDLE, abandon the frame with no frame_done, reset the address to 0 and enter VPORCH.
REQ-029 SHALL, on hsync during CAPT, abandon the partial byte without a write and go to HPORCH on the next line.
REQ-030 SHALL ignore hsyncs after frame completion until the next vsync.
REQ-031 SHALL give vsync precedence if both classifications could apply.

Reset
REQ-032 SHALL, on rst_n low, asynchronously clear px_we, px_addr, px_data, frame_done, locked, err_cnt, all counters and synchronisers, and set state IDLE.
REQ-033 SHALL, on reset mid-frame, write nothing further and resume with the next full vsync.

Configuration
REQ-034 SHALL, with NAS_VID_RX_ERRCNT_EN defined, increment err_cnt (saturating at 255) on each glitch, each REQ-028 abort and each REQ-029 truncation.
REQ-035 SHALL, without NAS_VID_RX_ERRCNT_EN, drive err_cnt constant 0 and omit the counter logic.

Verification
REQ-036 SHALL check: reset then sync low 2000 cycles -> locked=1 on rising edge+3 cycles, state VPORCH.
REQ-037 SHALL check: full frame, all dots 1 -> 12288 writes px_data=8'hFF, addresses 0..12287, a single frame_done with the last write.
REQ-038 SHALL check: dot pattern 1,0,0,0,0,0,0,1 at line 0 start -> px_addr=0, px_data=8'h81.
REQ-039 SHALL check: sync low 10 cycles mid-line -> no state change, err_cnt+1 with macro, err_cnt=0 without.
REQ-040 SHALL check: vsync after 100 captured lines -> no frame_done, next write px_addr=0.
REQ-041 SHALL check: rst_n low during CAPT -> all outputs 0 immediately, no px_we until after next vsync+V_START lines.

Source files
------------

// File: rtl/nas_vid_rx.sv
// Composite-sync video capture: classifies sync pulses, tracks the frame and packs
// sampled dots into bytes. Define NAS_VID_RX_ERRCNT_EN to enable the sync error counter.
module nas_vid_rx #(
   parameter int H_START   = 200,
   parameter int V_START   = 16,
   parameter int DOTS      = 384,
   parameter int LINES     = 256,
   parameter int HSYNC_MIN = 32,
   parameter int HSYNC_MAX = 96,
   parameter int VSYNC_MIN = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        vid_sync,
   input  logic        vid_data,
   output logic        px_we,
   output logic [13:0] px_addr,
   output logic [7:0]  px_data,
   output logic        frame_done,
   output logic        locked,
   output logic [7:0]  err_cnt
);
   localparam int WW = $clog2(VSYNC_MIN + 1);
   localparam int HW = $clog2(H_START + 1);
   localparam int VW = $clog2(V_START + 1);
   localparam int DW = $clog2(DOTS);
   localparam int LW = $clog2(LINES + 1);
   localparam logic [WW-1:0] W_VMIN = WW'(VSYNC_MIN);
   localparam logic [WW-1:0] W_HMIN = WW'(HSYNC_MIN);
   localparam logic [WW-1:0] W_HMAX = WW'(HSYNC_MAX);
   localparam logic [HW-1:0] H_LAST = HW'(H_START - 2);
   localparam logic [VW-1:0] V_LAST = VW'(V_START - 1);
   localparam logic [DW-1:0] D_LAST = DW'(DOTS - 1);
   localparam logic [LW-1:0] L_LAST = LW'(LINES - 1);
   localparam logic [13:0]   BPL    = 14'(DOTS / 8);

   typedef enum logic [2:0] {IDLE, VPORCH, HWAIT, HPORCH, CAPT} state_t;

   state_t          state_q, state_d;
   logic [1:0]      sync_q, data_q;
   logic            sync_s, data_s, sync_prev_q;
   logic            armed_q, armed_d;
   logic [WW-1:0]   wcnt_q, wcnt_d;
   logic            rise, is_v, is_h, is_g;
   logic [VW-1:0]   vcnt_q, vcnt_d;
   logic [HW-1:0]   hcnt_q, hcnt_d;
   logic            phase_q, phase_d;
   logic [DW-1:0]   dcnt_q, dcnt_d;
   logic [6:0]      sh_q, sh_d;
   logic [LW-1:0]   line_q, line_d;
   logic [13:0]     base_q, base_d, addr_q, addr_d;
   logic [7:0]      pxd_q, pxd_d;
   logic            we_q, we_d, fd_q, fd_d, locked_q, locked_d;
   logic            trunc, abort, do_sample, do_write, line_end, last_line, next_line;

   assign sync_s = sync_q[1];
   assign data_s = data_q[1];

   // A pulse only counts once a genuine falling edge has been seen, so the
   // synchroniser filling up after reset is never mistaken for a sync pulse.
   always_comb begin
      armed_d = armed_q;
      wcnt_d  = '0;
      if (sync_s)           armed_d = 1'b0;
      else if (sync_prev_q) armed_d = 1'b1;
      if (!sync_s) wcnt_d = (wcnt_q == W_VMIN) ? wcnt_q : wcnt_q + 1'b1;
   end

   always_comb begin
      rise = sync_s && !sync_prev_q && armed_q;
      is_v = rise && (wcnt_q >= W_VMIN);
      is_h = rise && !is_v && (wcnt_q >= W_HMIN) && (wcnt_q <= W_HMAX);
      is_g = rise && !is_v && !is_h;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (is_v) state_d = VPORCH;
      else begin
         unique case (state_q)
            VPORCH:  if (is_h && vcnt_q == V_LAST) state_d = HWAIT;
            HWAIT:   if (is_h) state_d = HPORCH;
            HPORCH:  if (hcnt_q == H_LAST) state_d = CAPT;
            CAPT: begin
               if (trunc)         state_d = last_line ? IDLE : HPORCH;
               else if (line_end) state_d = last_line ? IDLE : HWAIT;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      trunc     = is_h && (state_q == CAPT);
      abort     = is_v && (state_q != IDLE);
      do_sample = (state_q == CAPT) && !phase_q && !is_v && !is_h;
      do_write  = do_sample && (dcnt_q[2:0] == 3'd7);
      line_end  = do_sample && (dcnt_q == D_LAST);
      last_line = (line_q == L_LAST);
      next_line = trunc || line_end;
   end

   always_comb begin
      vcnt_d   = vcnt_q;
      hcnt_d   = '0;
      phase_d  = 1'b0;
      dcnt_d   = dcnt_q;
      sh_d     = sh_q;
      line_d   = line_q;
      base_d   = base_q;
      addr_d   = addr_q;
      pxd_d    = pxd_q;
      we_d     = 1'b0;
      fd_d     = 1'b0;
      locked_d = locked_q | is_v;
      if (state_q == VPORCH && is_h) vcnt_d = vcnt_q + 1'b1;
      if (state_q == HPORCH)         hcnt_d = hcnt_q + 1'b1;
      if (state_q == CAPT)           phase_d = ~phase_q;
      if (do_sample) begin
         sh_d   = {sh_q[5:0], data_s};
         dcnt_d = dcnt_q + 1'b1;
      end
      if (do_write) begin
         we_d   = 1'b1;
         pxd_d  = {sh_q, data_s};
         addr_d = base_q + 14'(dcnt_q >> 3);
         fd_d   = line_end && last_line;
      end
      // Truncated lines still advance the line base so addresses stay line-aligned.
      if (next_line) begin
         line_d = line_q + 1'b1;
         base_d = base_q + BPL;
         dcnt_d = '0;
      end
      if (is_v) begin
         vcnt_d = '0;
         line_d = '0;
         base_d = '0;
         dcnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= '0;
         data_q      <= '0;
         sync_prev_q <= 1'b0;
         armed_q     <= 1'b0;
         wcnt_q      <= '0;
         vcnt_q      <= '0;
         hcnt_q      <= '0;
         phase_q     <= 1'b0;
         dcnt_q      <= '0;
         sh_q        <= '0;
         line_q      <= '0;
         base_q      <= '0;
         addr_q      <= '0;
         pxd_q       <= '0;
         we_q        <= 1'b0;
         fd_q        <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], vid_sync};
         data_q      <= {data_q[0], vid_data};
         sync_prev_q <= sync_s;
         armed_q     <= armed_d;
         wcnt_q      <= wcnt_d;
         vcnt_q      <= vcnt_d;
         hcnt_q      <= hcnt_d;
         phase_q     <= phase_d;
         dcnt_q      <= dcnt_d;
         sh_q        <= sh_d;
         line_q      <= line_d;
         base_q      <= base_d;
         addr_q      <= addr_d;
         pxd_q       <= pxd_d;
         we_q        <= we_d;
         fd_q        <= fd_d;
         locked_q    <= locked_d;
      end
   end

`ifdef NAS_VID_RX_ERRCNT_EN
   logic [7:0] err_q, err_d;

   always_comb begin
      err_d = err_q;
      if ((is_g || abort || trunc) && err_q != 8'hFF) err_d = err_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= '0;
      else        err_q <= err_d;
   end

   assign err_cnt = err_q;
`else
   logic unused_err;
   assign unused_err = is_g | abort;
   assign err_cnt    = 8'h00;
`endif

   assign px_we      = we_q;
   assign px_addr    = addr_q;
   assign px_data    = pxd_q;
   assign frame_done = fd_q;
   assign locked     = locked_q;
endmodule

// File: tb/tb_nas_vid_rx.sv
// Scoreboard bench for nas_vid_rx: line/frame stimulus pushes expected byte writes,
// a forked monitor pops and compares them whenever px_we is seen.
module tb_nas_vid_rx;
   localparam int H_START = 20;
   localparam int V_START = 2;
   localparam int DOTS    = 64;
   localparam int LINES   = 16;
   localparam int BPL     = DOTS / 8;
   localparam int HS_W    = 40;
   localparam int TAIL    = 20;
`ifdef NAS_VID_RX_ERRCNT_EN
   localparam int ERR_EN = 1;
`else
   localparam int ERR_EN = 0;
`endif

   typedef struct {
      logic [13:0] addr;
      logic [7:0]  data;
      logic        fd;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n, vid_sync, vid_data;
   logic        px_we, frame_done, locked;
   logic [13:0] px_addr;
   logic [7:0]  px_data, err_cnt;
   wr_t         sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   nas_vid_rx #(
      .H_START(H_START), .V_START(V_START), .DOTS(DOTS), .LINES(LINES),
      .HSYNC_MIN(32), .HSYNC_MAX(96), .VSYNC_MIN(1024)
   ) dut (
      .clk(clk), .rst_n(rst_n), .vid_sync(vid_sync), .vid_data(vid_data),
      .px_we(px_we), .px_addr(px_addr), .px_data(px_data),
      .frame_done(frame_done), .locked(locked), .err_cnt(err_cnt)
   );

   always #31 clk = ~clk;

   initial begin
      #(62 * 150000);
      $display("FAIL watchdog: bench did not finish within cycle budget");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic monitor();
      wr_t e;
      forever begin
         @(negedge clk);
         if (frame_done && !px_we) chk("frame_done_without_write", 1, 0);
         if (px_we) begin
            if (sb.size() == 0) chk("unexpected_write", {px_addr, px_data}, 0 - 1);
            else begin
               e = sb.pop_front();
               chk("px_write", {px_addr, px_data, frame_done}, {e.addr, e.data, e.fd});
            end
         end
      end
   endtask

   function automatic logic [DOTS-1:0] pat(input int kind, input int l);
      logic [DOTS-1:0] d;
      for (int i = 0; i < DOTS; i++) begin
         case (kind)
            0:       d[i] = 1'b1;
            1:       d[i] = ((i * 7 + l * 3) % 5) < 2;
            default: d[i] = ((i + l) % 2) == 1;
         endcase
      end
      if (kind == 1 && l == 0) d[7:0] = 8'b1000_0001;
      return d;
   endfunction

   // One hsync plus a line of dots; cl >= 0 marks a captured line, gl >= 0 a glitch at that dot.
   task automatic line(input logic [DOTS-1:0] d, input int cl, input int gl);
      logic [7:0] acc;
      acc = '0;
      vid_sync = 1'b0;
      repeat (HS_W) @(negedge clk);
      vid_sync = 1'b1;
      repeat (H_START) @(negedge clk);
      for (int i = 0; i < DOTS; i++) begin
         vid_data = d[i];
         if (i == gl)     vid_sync = 1'b0;
         if (i == gl + 5) vid_sync = 1'b1;
         if (gl >= 0 && i == gl + 10) begin
            chk("glitch_state", 64'(int'(dut.state_q)), 4);
            chk("glitch_err", err_cnt, ERR_EN);
         end
         if (i % 8 == 0) acc = '0;
         acc = {acc[6:0], d[i]};
         if (cl >= 0 && i % 8 == 7)
            sb.push_back('{addr: 14'(cl * BPL + i / 8), data: acc,
                           fd: (cl == LINES - 1 && i == DOTS - 1)});
         repeat (2) @(negedge clk);
      end
      vid_data = 1'b0;
      repeat (TAIL) @(negedge clk);
   endtask

   task automatic vsync(input int w);
      vid_sync = 1'b0;
      repeat (w) @(negedge clk);
      vid_sync = 1'b1;
      repeat (100) @(negedge clk);
   endtask

   task automatic body(input int kind, input int ncap, input int gl_line);
      for (int l = 0; l < V_START; l++) line('0, -1, -1);
      for (int l = 0; l < ncap; l++) line(pat(kind, l), l, (l == gl_line) ? 20 : -1);
   endtask

   initial begin
      fork
         monitor();
      join_none
      rst_n = 1'b0; vid_sync = 1'b1; vid_data = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("reset_outputs", {px_we, px_addr, px_data, frame_done, locked, err_cnt}, 0);
      chk("reset_state", 64'(int'(dut.state_q)), 0);

      // long sync pulse: lock appears three cycles after its trailing edge
      vid_sync = 1'b0;
      repeat (2000) @(negedge clk);
      vid_sync = 1'b1;
      @(negedge clk);
      chk("lock_early", locked, 0);
      repeat (2) @(negedge clk);
      chk("lock_set", locked, 1);
      chk("lock_state", 64'(int'(dut.state_q)), 1);
      repeat (97) @(negedge clk);

      // all-ones frame with a short glitch inside captured line 5
      body(0, LINES, 5);
      line('1, -1, -1);
      chk("idle_after_frame", 64'(int'(dut.state_q)), 0);
      chk("err_after_glitch", err_cnt, ERR_EN);

      // mixed pattern frame; line 0 starts with byte 8'h81
      vsync(1100);
      body(1, LINES, -1);

      // frame abandoned by vsync after 10 lines, then a full frame from address 0
      vsync(1100);
      body(2, 10, -1);
      vsync(1100);
      chk("abort_state", 64'(int'(dut.state_q)), 1);
      chk("err_after_abort", err_cnt, 2 * ERR_EN);
      body(2, LINES, -1);

      // reset asserted during capture of line 0
      vsync(1100);
      for (int l = 0; l < V_START; l++) line('0, -1, -1);
      vid_sync = 1'b0;
      repeat (HS_W) @(negedge clk);
      vid_sync = 1'b1;
      repeat (H_START + 6) @(negedge clk);
      chk("pre_reset_state", 64'(int'(dut.state_q)), 4);
      vid_data = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("midframe_reset_outputs", {px_we, px_addr, px_data, frame_done, locked, err_cnt}, 0);
      chk("midframe_reset_state", 64'(int'(dut.state_q)), 0);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * DOTS) @(negedge clk);
      vid_data = 1'b0;
      for (int l = 1; l < LINES; l++) line('1, -1, -1);
      chk("no_lock_before_vsync", locked, 0);

      vsync(1100);
      body(1, LINES, -1);
      chk("final_locked", locked, 1);
      chk("final_err", err_cnt, 0);
      repeat (20) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
